tile_scheduler: RTL

- Producer side of the tile-drawing interface: owns the four falling-tile positions (x1..x4, y1..y4) and drives the tile drawer's start/done handshake.
- Scrolls all tiles down on a frame tick. Respawns the tile that leaves the screen at the top, in a pseudo-random lane.
- Sits between game control (go/halt) and the tile drawer feeding the VGA adapter.

---
 rtl/tile_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - falling-tile position owner and tile-drawer handshake driver
module tile_scheduler #(
  parameter int unsigned TICK_DIV = 833333,
  parameter int          STEP     = 1,
  parameter int          LANE_W   = 40,
  parameter int          BAND_H   = 30,
  parameter int          SCREEN_H = 120,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       halt,
  input  logic       draw_done,
  output logic       draw_start,
  output logic [7:0] x1,
  output logic [7:0] x2,
  output logic [7:0] x3,
  output logic [7:0] x4,
  output logic [6:0] y1,
  output logic [6:0] y2,
  output logic [6:0] y3,
  output logic [6:0] y4,
  output logic       busy,
  output logic       wrapped,
  output logic [1:0] wrap_lane,
  output logic       tick_overrun
);

  typedef enum logic [2:0] {IDLE, INIT, START, WAIT_DONE, WAIT_TICK, UPDATE} state_t;

  localparam logic [7:0]  SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [23:0]     cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [3:0][7:0] x_q, x_d;
  logic [3:0][6:0] y_q, y_d;
  logic [3:0][7:0] sum;
  logic            draw_start_q, draw_start_d;
  logic            busy_q, busy_d;
  logic            wrapped_q, wrapped_d;
  logic [1:0]      wrap_lane_q, wrap_lane_d;
  logic            tick_overrun_q, tick_overrun_d;
  logic            tick;

  function automatic logic [7:0] lane_x(input logic [1:0] lane);
    return 8'(int'(lane) * LANE_W);
  endfunction

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    tick        = (state_q != IDLE) && (cnt_q == TICK_LAST);
    cnt_d       = (state_q == IDLE || tick) ? 24'd0 : cnt_q + 24'd1;
    x_d         = x_q;
    y_d         = y_q;
    wrapped_d   = 1'b0;
    wrap_lane_d = wrap_lane_q;
    for (int k = 0; k < 4; k++) sum[k] = {1'b0, y_q[k]} + 8'(STEP);

    case (state_q)
      IDLE: if (go) state_d = INIT;
      INIT: begin
        for (int k = 0; k < 4; k++) begin
          y_d[k] = 7'(k * BAND_H);
          x_d[k] = lane_x(lfsr_q[2*k +: 2]);
        end
        state_d = START;
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: if (draw_done) state_d = halt ? IDLE : WAIT_TICK;
      WAIT_TICK: begin
        if (halt) state_d = IDLE;
        else if (pending_q || tick) state_d = UPDATE;
      end
      UPDATE: begin
        // Every wrapping tile shares the same lane draw, so one wrap_lane covers them all.
        for (int k = 0; k < 4; k++) begin
          if (sum[k] >= 8'(SCREEN_H)) begin
            y_d[k]    = 7'(sum[k] - 8'(SCREEN_H));
            x_d[k]    = lane_x(lfsr_q[1:0]);
            wrapped_d = 1'b1;
          end else begin
            y_d[k] = sum[k][6:0];
          end
        end
        if (wrapped_d) wrap_lane_d = lfsr_q[1:0];
        state_d = START;
      end
      default: state_d = IDLE;
    endcase

    tick_overrun_d = tick && pending_q;
    pending_d      = pending_q || tick;
    if (state_d == UPDATE || state_q == IDLE) pending_d = 1'b0;
    draw_start_d   = (state_d == START);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      lfsr_q         <= SEED_EFF;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      draw_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      wrapped_q      <= 1'b0;
      wrap_lane_q    <= 2'd0;
      tick_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      x_q            <= x_d;
      y_q            <= y_d;
      draw_start_q   <= draw_start_d;
      busy_q         <= busy_d;
      wrapped_q      <= wrapped_d;
      wrap_lane_q    <= wrap_lane_d;
      tick_overrun_q <= tick_overrun_d;
    end
  end

  assign {x4, x3, x2, x1} = x_q;
  assign {y4, y3, y2, y1} = y_q;
  assign draw_start   = draw_start_q;
  assign busy         = busy_q;
  assign wrapped      = wrapped_q;
  assign wrap_lane    = wrap_lane_q;
  assign tick_overrun = tick_overrun_q;

endmodule
